digit_serial_adder: RTL and testbench
=====================================

DIGIT_SERIAL_ADDER -- requirements
Module: digit_serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand and sum width in bits.
REQ-002 SHALL have parameter DIGIT, default 4: bits added per cycle; WIDTH SHALL be an integer multiple of DIGIT.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1: operands a, b, ci and op are valid.
REQ-006 SHALL have port in_ready, output, 1: block can accept operands.
REQ-007 SHALL have port a, input, WIDTH: first operand.
REQ-008 SHALL have port b, input, WIDTH: second operand.
REQ-009 SHALL have port ci, input, 1: carry-in, used for add only.
REQ-010 SHALL have port op, input, 1: 0 means add and 1 means subtract; ignored without SUB_EN.
REQ-011 SHALL have port out_valid, output, 1: result is valid.
REQ-012 SHALL have port out_ready, input, 1: consumer accepts the result.
REQ-013 SHALL have port s, output, WIDTH: sum or difference.
REQ-014 SHALL have port co, output, 1: carry-out of the MSB; for subtract, 1 means no borrow.
REQ-015 SHALL have port ovf, output, 1: two's-complement overflow, computed as carry into MSB XOR carry out of MSB.

Function
REQ-016 SHALL implement the FSM states IDLE, RUN and DONE, with N = WIDTH/DIGIT.
REQ-017 SHALL assert in_ready only in IDLE; out_valid only in DONE.
REQ-018 SHALL, in IDLE with in_valid=1 at a clock edge, capture a and b into shift registers, preset the carry register to ci (add) or 1 (subtract, with b inverted), clear the digit counter, and enter RUN.
REQ-019 SHALL, each RUN cycle, add the least-significant DIGIT bits of the operand registers plus the carry register through a DIGIT-long ripple of full-adder cells, shift the digit result into s from the MSB end, shift the operands right by DIGIT, and update the carry register.
REQ-020 SHALL, during the final RUN cycle (counter = N-1), also register the carry into the MSB and enter DONE.
REQ-021 SHALL assert out_valid exactly N clock edges after the accepting edge; for example, DIGIT=WIDTH gives 1-cycle latency.
REQ-022 SHALL hold s, co and ovf stable in DONE until out_ready=1; on that edge it SHALL enter IDLE.
REQ-023 SHALL NOT overlap transactions: an accept in the cycle after the out handshake is the minimum spacing.
REQ-024 SHALL ignore a, b, ci, op and in_valid outside IDLE.
REQ-025 SHALL ignore out_ready outside DONE.
REQ-026 SHALL ignore a, b, ci and op changes after the accepting edge.
REQ-027 SHALL make all arithmetic modulo 2^WIDTH; co and ovf SHALL be defined for every operand pair, including all-ones + all-ones with ci=1.

Reset
REQ-028 SHALL, while rst=1, asynchronously force state IDLE and counter 0.
REQ-029 SHALL, while rst=1, force s, co and ovf to 0, out_valid to 0 and carry register to 0.
REQ-030 SHALL drive in_ready=1 from the first clock after rst deasserts.
REQ-031 SHALL, on reset in RUN or DONE, discard the transaction and produce no out_valid for it.

Configuration
REQ-032 SHALL, with SUB_EN defined, honour op: op=1 computes a - b as a + ~b + 1, and ci is ignored.
REQ-033 SHALL, without SUB_EN, compile out the op logic; op is unconnected internally and every transaction is a + b + ci.

Structure
REQ-034 SHALL place in shared package adder_pkg: the FSM state typedef (IDLE/RUN/DONE), the op encoding constants OP_ADD=0 and OP_SUB=1, and the function computing the counter width from N.
REQ-035 SHALL instantiate sub-module fa_cell (1-bit full adder: a, b, ci -> s, co) DIGIT times per digit slice; no other sub-modules.

Verification
REQ-036 SHALL cover, at WIDTH=16, DIGIT=4: a=0xFFFF, b=0x0001, ci=0 -> s=0x0000, co=1, ovf=0, out_valid exactly 4 edges after accept.
REQ-037 SHALL cover a=0x7FFF, b=0x0001, ci=0 -> s=0x8000, co=0, ovf=1; and a=0xFFFF, b=0xFFFF, ci=1 -> s=0xFFFF, co=1, ovf=0.
REQ-038 SHALL cover backpressure: out_ready held 0 for 3 cycles in DONE -> s, co, ovf and out_valid stable, in_ready=0, new in_valid ignored; IDLE on the edge where out_ready=1.
REQ-039 SHALL cover reset mid-RUN (rst pulsed at counter 2) -> out_valid never asserts, s=0, in_ready=1 after release, next transaction correct.
REQ-040 SHALL cover, with SUB_EN defined: op=1, a=0x0005, b=0x0007 -> s=0xFFFE, co=0, ovf=0; op=1, a=0x8000, b=0x0001 -> s=0x7FFF, co=1, ovf=1.
REQ-041 SHALL cover parameter sweep DIGIT=1 and DIGIT=16: random operands match the reference sum, with latencies 16 and 1.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared types and helpers for the digit-serial adder: FSM state encoding,
// op encoding and the digit-counter width calculation.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // A single-digit configuration still needs a 1-bit counter to compare against.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fa_cell.sv
// One-bit full adder; the digit slice of the serial adder is a ripple of these.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/digit_serial_adder.sv
// Digit-serial adder: WIDTH-bit add (or subtract when SUB_EN is defined),
// DIGIT bits per cycle through a ripple of fa_cell, with valid/ready handshakes.
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// RUN   | adding one digit per cycle, N = WIDTH/DIGIT cycles
// DONE  | result held on s/co/ovf, out_valid=1 until out_ready
module digit_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  state_t state, state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh, b_sh, s_reg, s_next;
  logic             carry, co_reg, ovf_reg;
  logic [DIGIT-1:0] d_sum;
  logic [DIGIT:0]   c_chain;
  logic             accept, step, last, sub;

`ifdef SUB_EN
  assign sub = (op == OP_SUB);
`else
  logic unused_op;
  assign sub       = 1'b0;
  assign unused_op = op;
`endif

  assign c_chain[0] = carry;

  for (genvar i = 0; i < DIGIT; i++) begin : g_slice
    fa_cell u_fa (
      .a  (a_sh[i]),
      .b  (b_sh[i]),
      .ci (c_chain[i]),
      .s  (d_sum[i]),
      .co (c_chain[i+1])
    );
  end

  // New digit enters at the MSB end; after N steps the LSB digit is at the bottom.
  if (DIGIT == WIDTH) begin : g_s_full
    assign s_next = d_sum;
  end else begin : g_s_shift
    assign s_next = {d_sum, s_reg[WIDTH-1:DIGIT]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    step      = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept   = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == CNT_LAST) begin
          last     = 1'b1;
          state_nx = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      a_sh    <= '0;
      b_sh    <= '0;
      s_reg   <= '0;
      carry   <= 1'b0;
      co_reg  <= 1'b0;
      ovf_reg <= 1'b0;
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= sub ? ~b : b;
      carry <= sub ? 1'b1 : ci;
      cnt   <= '0;
    end else if (step) begin
      a_sh  <= a_sh >> DIGIT;
      b_sh  <= b_sh >> DIGIT;
      s_reg <= s_next;
      carry <= c_chain[DIGIT];
      cnt   <= last ? '0 : cnt + CW'(1);
      if (last) begin
        co_reg  <= c_chain[DIGIT];
        ovf_reg <= c_chain[DIGIT] ^ c_chain[DIGIT-1];
      end
    end
  end

  assign s   = s_reg;
  assign co  = co_reg;
  assign ovf = ovf_reg;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Bench for digit_serial_adder: three instances (DIGIT=1,4,16) share stimulus
// and are checked every cycle against an arithmetic reference model.
module tb_digit_serial_adder;

  localparam int NI = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        ci = 1'b0;
  logic        op = 1'b0;

  logic        in_ready_v [NI];
  logic        out_valid_v[NI];
  logic        co_v       [NI];
  logic        ovf_v      [NI];
  logic [15:0] s_v        [NI];

  bit          pend   [NI];
  int          acc_cyc[NI];
  logic [17:0] exp_r  [NI];
  logic [17:0] got_r  [NI];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  digit_serial_adder #(.WIDTH(16), .DIGIT(1)) dut_d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[0]),
    .a(a), .b(b), .ci(ci), .op(op), .out_valid(out_valid_v[0]),
    .out_ready(out_ready), .s(s_v[0]), .co(co_v[0]), .ovf(ovf_v[0]));

  digit_serial_adder #(.WIDTH(16), .DIGIT(4)) dut_d4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[1]),
    .a(a), .b(b), .ci(ci), .op(op), .out_valid(out_valid_v[1]),
    .out_ready(out_ready), .s(s_v[1]), .co(co_v[1]), .ovf(ovf_v[1]));

  digit_serial_adder #(.WIDTH(16), .DIGIT(16)) dut_d16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[2]),
    .a(a), .b(b), .ci(ci), .op(op), .out_valid(out_valid_v[2]),
    .out_ready(out_ready), .s(s_v[2]), .co(co_v[2]), .ovf(ovf_v[2]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat_of(input int i);
    case (i)
      0:       return 16;
      1:       return 4;
      default: return 1;
    endcase
  endfunction

  // Reference result {co, ovf, s}; overflow from the sign rule.
  function automatic logic [17:0] ref_calc(input logic [15:0] x, input logic [15:0] y,
                                           input logic cin, input logic opv);
    logic        sub;
    logic [15:0] yy;
    logic [16:0] full;
    logic        v;
`ifdef SUB_EN
    sub = opv;
`else
    sub = 1'b0 & opv;
`endif
    yy   = sub ? ~y : y;
    full = {1'b0, x} + {1'b0, yy} + {16'd0, (sub ? 1'b1 : cin)};
    v    = (x[15] == yy[15]) && (full[15] != x[15]);
    return {full[16], v, full[15:0]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic fail_bound(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: wait bound expired (t=%0t)", nm, $time);
  endtask

  always @(negedge clk) begin
    int d;
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        chk($sformatf("d%0d_rst_out_valid", i), 32'(out_valid_v[i]), 32'd0);
        chk($sformatf("d%0d_rst_s", i), 32'(s_v[i]), 32'd0);
        chk($sformatf("d%0d_rst_co_ovf", i), {30'd0, co_v[i], ovf_v[i]}, 32'd0);
      end else begin
        chk($sformatf("d%0d_in_ready", i), 32'(in_ready_v[i]), 32'(!pend[i]));
        if (pend[i]) begin
          d = cyc - acc_cyc[i];
          if (d < lat_of(i))
            chk($sformatf("d%0d_early_valid", i), 32'(out_valid_v[i]), 32'd0);
          else if (d == lat_of(i))
            chk($sformatf("d%0d_latency", i), 32'(out_valid_v[i]), 32'd1);
          if (out_valid_v[i]) begin
            got_r[i] = {co_v[i], ovf_v[i], s_v[i]};
            chk($sformatf("d%0d_s", i), 32'(s_v[i]), 32'(exp_r[i][15:0]));
            chk($sformatf("d%0d_co", i), 32'(co_v[i]), 32'(exp_r[i][17]));
            chk($sformatf("d%0d_ovf", i), 32'(ovf_v[i]), 32'(exp_r[i][16]));
            if (out_ready) pend[i] = 1'b0;
          end
        end else begin
          chk($sformatf("d%0d_spurious_valid", i), 32'(out_valid_v[i]), 32'd0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!(in_ready_v[0] && in_ready_v[1] && in_ready_v[2]) && k < 100) begin
      tick();
      k++;
    end
    if (k >= 100) fail_bound("wait_ready");
  endtask

  task automatic issue(input logic [15:0] x, input logic [15:0] y,
                       input logic cin, input logic opv);
    wait_ready();
    a = x; b = y; ci = cin; op = opv; in_valid = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      pend[i]    = 1'b1;
      acc_cyc[i] = cyc;
      exp_r[i]   = ref_calc(x, y, cin, opv);
    end
    #1;
    in_valid = 1'b0;
    a  = 16'($urandom);
    b  = 16'($urandom);
    ci = 1'($urandom);
    op = 1'($urandom);
  endtask

  task automatic drain(input bit rand_bp);
    int k = 0;
    while ((pend[0] || pend[1] || pend[2]) && k < 300) begin
      out_ready = rand_bp ? 1'($urandom) : 1'b1;
      tick();
      k++;
    end
    out_ready = 1'b1;
    if (k >= 300) begin
      fail_bound("drain");
      for (int i = 0; i < NI; i++) pend[i] = 1'b0;
    end
  endtask

  task automatic run_dir(input string nm, input logic [15:0] x, input logic [15:0] y,
                         input logic cin, input logic opv,
                         input logic [15:0] es, input logic eco, input logic eovf);
    issue(x, y, cin, opv);
    drain(1'b0);
    chk({nm, "_s"},   32'(got_r[1][15:0]), 32'(es));
    chk({nm, "_co"},  32'(got_r[1][17]),   32'(eco));
    chk({nm, "_ovf"}, 32'(got_r[1][16]),   32'(eovf));
  endtask

  initial begin
    logic [15:0] snap;
    int k;
    for (int i = 0; i < NI; i++) begin
      pend[i] = 1'b0; acc_cyc[i] = 0; exp_r[i] = '0; got_r[i] = '0;
    end
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("reset_in_ready", 32'(in_ready_v[1]), 32'd1);
    chk("reset_s", 32'(s_v[1]), 32'd0);

    run_dir("wrap",     16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_dir("pos_ovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_dir("all_ones", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0);
`ifdef SUB_EN
    run_dir("sub_neg",  16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_dir("sub_ovf",  16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
`endif

    // Backpressure: results held in DONE while new operands are offered.
    out_ready = 1'b0;
    issue(16'h1234, 16'h4321, 1'b1, 1'b0);
    k = 0;
    while (!(out_valid_v[0] && out_valid_v[1] && out_valid_v[2]) && k < 40) begin
      tick();
      k++;
    end
    if (k >= 40) fail_bound("bp_wait_valid");
    snap = s_v[1];
    for (int j = 0; j < 3; j++) begin
      in_valid = 1'b1;
      a = 16'($urandom);
      b = 16'($urandom);
      tick();
      chk("bp_hold_s", 32'(s_v[1]), 32'(snap));
      chk("bp_hold_valid", 32'(out_valid_v[1]), 32'd1);
      chk("bp_in_ready", 32'(in_ready_v[1]), 32'd0);
    end
    in_valid = 1'b0;
    chk("bp_s", 32'(s_v[1]), 32'h5556);
    out_ready = 1'b1;
    tick();
    chk("bp_idle_in_ready", 32'(in_ready_v[1]), 32'd1);
    chk("bp_idle_valid", 32'(out_valid_v[1]), 32'd0);

    // Reset while the DIGIT=4 instance sits at counter 2.
    issue(16'hABCD, 16'h1111, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    for (int i = 0; i < NI; i++) pend[i] = 1'b0;
    tick();
    chk("midrst_s", 32'(s_v[1]), 32'd0);
    rst = 1'b0;
    tick();
    chk("midrst_in_ready", 32'(in_ready_v[1]), 32'd1);
    chk("midrst_s_after", 32'(s_v[1]), 32'd0);
    repeat (4) tick();
    run_dir("after_rst", 16'h0F0F, 16'h00F1, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0);

    // Random operands with random backpressure.
    for (int t = 0; t < 40; t++) begin
      issue(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      drain(1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
